// File: rtl/loader_pkg.sv
// Shared constants and state encoding for the UART-driven memory loader.
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

package loader_pkg;
    localparam logic [7:0] CMD_WRITE  = 8'h57;
    localparam logic [7:0] CMD_READ   = 8'h52;
    localparam logic [7:0] CMD_GO     = 8'h47;
    localparam logic [7:0] ACK_BYTE   = 8'h06;
    localparam logic [7:0] NAK_BYTE   = 8'h15;
    localparam logic [2:0] WIDTH_BYTE = 3'd1;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_HDR,
        ST_W_RX,
        ST_W_BUS,
        ST_RD_BUS,
        ST_RD_TX,
        ST_ACK,
        ST_SUM,
        ST_GO,
        ST_NAK
    } loader_state_t;

    function automatic logic is_valid_cmd(input logic [7:0] b);
        return (b == CMD_WRITE) || (b == CMD_READ) || (b == CMD_GO);
    endfunction
endpackage

// File: rtl/uart_loader.sv
// Byte-serial command interpreter that drives single-byte memory bus reads/writes
// and hands control to a boot address.
module uart_loader
    import loader_pkg::*;
#(
    parameter int DATA_WIDTH = `DATA_WIDTH
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic [7:0]            i_rx_data,
    input  logic                  i_rx_valid,
    output logic                  o_rx_ready,
    output logic [7:0]            o_tx_data,
    output logic                  o_tx_valid,
    input  logic                  i_tx_ready,
    output logic [31:0]           o_addr,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic                  o_wr_valid,
    input  logic                  i_wr_ready,
    output logic [2:0]            o_wr_width,
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic                  i_rd_valid,
    output logic                  o_rd_ready,
    output logic                  o_go,
    output logic [31:0]           o_entry,
    output logic                  o_busy
);
    loader_state_t state_q, state_d;
    logic [7:0]  cmd_q, cmd_d;
    logic [47:0] hdr_q, hdr_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [31:0] addr_q, addr_d;
    logic [15:0] rem_q, rem_d;
    logic [7:0]  sum_q, sum_d;
    logic [7:0]  wdata_q, wdata_d;
    logic [31:0] entry_q, entry_d;
    logic [7:0]  tx_data_q, tx_data_d;
    logic        rx_ready_q, rx_ready_d;
    logic        wr_valid_q, wr_valid_d;
    logic        rd_ready_q, rd_ready_d;
    logic        tx_valid_q, tx_valid_d;
    logic        go_q, go_d;
    logic        busy_q, busy_d;
    logic        rx_fire, wr_fire, rd_fire, tx_fire;
    logic        unused_data;

    assign rx_fire     = i_rx_valid & rx_ready_q;
    assign wr_fire     = wr_valid_q & i_wr_ready;
    assign rd_fire     = rd_ready_q & i_rd_valid;
    assign tx_fire     = tx_valid_q & i_tx_ready;
    assign unused_data = ^i_data;

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        cmd_d   = cmd_q;
        hdr_d   = hdr_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        rem_d   = rem_q;
        sum_d   = sum_q;
        wdata_d = wdata_q;
        entry_d = entry_q;
        case (state_q)
            ST_IDLE: if (rx_fire) begin
                cmd_d   = i_rx_data;
                sum_d   = 8'd0;
                cnt_d   = 3'd0;
                state_d = is_valid_cmd(i_rx_data) ? ST_HDR : ST_NAK;
            end
            ST_HDR: if (rx_fire) begin
                // Bytes enter at the top so the little-endian fields land in place.
                hdr_d = {i_rx_data, hdr_q[47:8]};
                cnt_d = cnt_q + 3'd1;
                if (cnt_q == 3'd5) begin
                    addr_d = hdr_d[31:0];
                    rem_d  = hdr_d[47:32];
                    if (cmd_q == CMD_GO || hdr_d[47:32] == 16'd0) state_d = ST_ACK;
                    else if (cmd_q == CMD_WRITE)                 state_d = ST_W_RX;
                    else                                         state_d = ST_RD_BUS;
                end
            end
            ST_W_RX: if (rx_fire) begin
                wdata_d = i_rx_data;
                sum_d   = sum_q + i_rx_data;
                state_d = ST_W_BUS;
            end
            ST_W_BUS: if (wr_fire) begin
                addr_d  = addr_q + 32'd1;
                rem_d   = rem_q - 16'd1;
                state_d = (rem_q == 16'd1) ? ST_ACK : ST_W_RX;
            end
            ST_RD_BUS: if (rd_fire) state_d = ST_RD_TX;
            ST_RD_TX: if (tx_fire) begin
                addr_d  = addr_q + 32'd1;
                rem_d   = rem_q - 16'd1;
                state_d = (rem_q == 16'd1) ? ST_ACK : ST_RD_BUS;
            end
            ST_ACK: if (tx_fire) begin
                if (cmd_q == CMD_WRITE) state_d = ST_SUM;
                else if (cmd_q == CMD_GO) begin
                    entry_d = addr_q;
                    state_d = ST_GO;
                end else state_d = ST_IDLE;
            end
            ST_SUM, ST_NAK: if (tx_fire) state_d = ST_IDLE;
            ST_GO:   state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so every port comes straight off a flop.
    always_comb begin
        rx_ready_d = (state_d == ST_IDLE) || (state_d == ST_HDR) || (state_d == ST_W_RX);
        wr_valid_d = (state_d == ST_W_BUS);
        rd_ready_d = (state_d == ST_RD_BUS);
        tx_valid_d = (state_d == ST_RD_TX) || (state_d == ST_ACK) ||
                     (state_d == ST_SUM)   || (state_d == ST_NAK);
        go_d       = (state_d == ST_GO);
        busy_d     = (state_d != ST_IDLE);
        tx_data_d  = tx_data_q;
        case (state_d)
            ST_RD_TX: if (state_q == ST_RD_BUS) tx_data_d = i_data[7:0];
            ST_ACK:   tx_data_d = ACK_BYTE;
            ST_SUM:   tx_data_d = sum_d;
            ST_NAK:   tx_data_d = NAK_BYTE;
            default:  tx_data_d = tx_data_q;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            cmd_q      <= 8'd0;
            hdr_q      <= 48'd0;
            cnt_q      <= 3'd0;
            addr_q     <= 32'd0;
            rem_q      <= 16'd0;
            sum_q      <= 8'd0;
            wdata_q    <= 8'd0;
            entry_q    <= 32'd0;
            tx_data_q  <= 8'd0;
            rx_ready_q <= 1'b0;
            wr_valid_q <= 1'b0;
            rd_ready_q <= 1'b0;
            tx_valid_q <= 1'b0;
            go_q       <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            cmd_q      <= cmd_d;
            hdr_q      <= hdr_d;
            cnt_q      <= cnt_d;
            addr_q     <= addr_d;
            rem_q      <= rem_d;
            sum_q      <= sum_d;
            wdata_q    <= wdata_d;
            entry_q    <= entry_d;
            tx_data_q  <= tx_data_d;
            rx_ready_q <= rx_ready_d;
            wr_valid_q <= wr_valid_d;
            rd_ready_q <= rd_ready_d;
            tx_valid_q <= tx_valid_d;
            go_q       <= go_d;
            busy_q     <= busy_d;
        end
    end

    assign o_rx_ready = rx_ready_q;
    assign o_tx_data  = tx_data_q;
    assign o_tx_valid = tx_valid_q;
    assign o_addr     = addr_q;
    assign o_data     = DATA_WIDTH'(wdata_q);
    assign o_wr_valid = wr_valid_q;
    assign o_wr_width = WIDTH_BYTE;
    assign o_rd_ready = rd_ready_q;
    assign o_go       = go_q;
    assign o_entry    = entry_q;
    assign o_busy     = busy_q;
endmodule

// File: tb/tb_uart_loader.sv
// Directed bench for uart_loader: bus/TX responders on the falling edge, one task per scenario.
module tb_uart_loader;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [7:0]    i_rx_data = 8'd0;
    logic          i_rx_valid = 1'b0;
    logic          o_rx_ready;
    logic [7:0]    o_tx_data;
    logic          o_tx_valid;
    logic          i_tx_ready = 1'b0;
    logic [31:0]   o_addr;
    logic [DW-1:0] o_data;
    logic          o_wr_valid;
    logic          i_wr_ready = 1'b0;
    logic [2:0]    o_wr_width;
    logic [DW-1:0] i_data = '0;
    logic          i_rd_valid = 1'b0;
    logic          o_rd_ready;
    logic          o_go;
    logic [31:0]   o_entry;
    logic          o_busy;

    int checks = 0;
    int fails  = 0;

    logic [7:0]  mem [logic [31:0]];
    logic [7:0]  tx_q [$];
    logic [31:0] wa_q [$];
    logic [7:0]  wd_q [$];
    int rd_cnt = 0, go_cnt = 0, stab_err = 0;
    int wr_delay = 0, wr_wait = 0, tx_stall = 0, stall_after = 0;
    logic wr_pend = 1'b0;
    logic [31:0] p_addr;
    logic [DW-1:0] p_data;

    uart_loader #(.DATA_WIDTH(DW)) dut (
        .i_clk(clk), .i_rst(rst_n),
        .i_rx_data(i_rx_data), .i_rx_valid(i_rx_valid), .o_rx_ready(o_rx_ready),
        .o_tx_data(o_tx_data), .o_tx_valid(o_tx_valid), .i_tx_ready(i_tx_ready),
        .o_addr(o_addr), .o_data(o_data), .o_wr_valid(o_wr_valid), .i_wr_ready(i_wr_ready),
        .o_wr_width(o_wr_width), .i_data(i_data), .i_rd_valid(i_rd_valid), .o_rd_ready(o_rd_ready),
        .o_go(o_go), .o_entry(o_entry), .o_busy(o_busy)
    );

    always #5 clk = ~clk;

    // Responders: drive readies for the coming rising edge and log what will transfer on it.
    always @(negedge clk) begin
        if (!rst_n) begin
            i_wr_ready = 1'b0; i_rd_valid = 1'b0; i_tx_ready = 1'b0;
            wr_wait = 0; wr_pend = 1'b0;
        end else begin
            if (o_wr_valid) begin
                if (wr_pend && (o_addr !== p_addr || o_data !== p_data)) stab_err++;
                if (wr_wait >= wr_delay) i_wr_ready = 1'b1;
                else begin i_wr_ready = 1'b0; wr_wait++; end
                wr_pend = 1'b1; p_addr = o_addr; p_data = o_data;
                if (i_wr_ready) begin
                    wa_q.push_back(o_addr); wd_q.push_back(o_data[7:0]);
                    mem[o_addr] = o_data[7:0];
                    wr_pend = 1'b0; wr_wait = 0;
                end
            end else begin
                i_wr_ready = 1'b0; wr_wait = 0; wr_pend = 1'b0;
            end
            i_rd_valid = o_rd_ready;
            i_data = mem.exists(o_addr) ? DW'(mem[o_addr]) : '0;
            if (o_rd_ready) rd_cnt++;
            if (stall_after > 0 && tx_q.size() == stall_after) begin
                tx_stall = 10; stall_after = 0;
            end
            if (tx_stall > 0) begin
                i_tx_ready = 1'b0;
                if (o_tx_valid) tx_stall--;
            end else i_tx_ready = 1'b1;
            if (o_tx_valid && i_tx_ready) tx_q.push_back(o_tx_data);
            if (o_go) go_cnt++;
        end
    end

    task automatic send_byte(input logic [7:0] b);
        int n;
        @(negedge clk);
        i_rx_valid = 1'b1; i_rx_data = b;
        for (n = 0; n < 2000; n++) begin
            if (o_rx_ready) break;
            @(negedge clk);
        end
        checks++;
        if (n >= 2000) begin fails++; $display("FAIL rx_timeout byte=%h got no o_rx_ready, required o_rx_ready=1", b); end
        @(posedge clk); #1;
        i_rx_valid = 1'b0;
    endtask

    task automatic send_hdr(input logic [7:0] cmd, input logic [31:0] a, input logic [15:0] len);
        send_byte(cmd);
        for (int i = 0; i < 4; i++) send_byte(a[8*i +: 8]);
        send_byte(len[7:0]);
        send_byte(len[15:8]);
    endtask

    task automatic wait_idle();
        int n;
        for (n = 0; n < 3000; n++) begin
            @(negedge clk);
            if (!o_busy) break;
        end
        checks++;
        if (n >= 3000) begin fails++; $display("FAIL idle_timeout got o_busy=1, required o_busy=0"); end
    endtask

    task automatic clear_logs();
        tx_q.delete(); wa_q.delete(); wd_q.delete();
        rd_cnt = 0; go_cnt = 0; stab_err = 0;
    endtask

    task automatic check_tx(input string name, input logic [7:0] e [$]);
        checks++;
        if (tx_q.size() != e.size()) begin
            fails++; $display("FAIL %s tx_count got %0d required %0d", name, tx_q.size(), e.size());
        end else begin
            for (int i = 0; i < e.size(); i++) begin
                checks++;
                if (tx_q[i] !== e[i]) begin
                    fails++; $display("FAIL %s tx[%0d] got %h required %h", name, i, tx_q[i], e[i]);
                end
            end
        end
    endtask

    task automatic check_wr(input string name, input logic [31:0] ea [$], input logic [7:0] ed [$]);
        checks++;
        if (wa_q.size() != ea.size()) begin
            fails++; $display("FAIL %s wr_count got %0d required %0d", name, wa_q.size(), ea.size());
        end else begin
            for (int i = 0; i < ea.size(); i++) begin
                checks++;
                if (wa_q[i] !== ea[i] || wd_q[i] !== ed[i]) begin
                    fails++; $display("FAIL %s wr[%0d] got %h:%h required %h:%h", name, i, wa_q[i], wd_q[i], ea[i], ed[i]);
                end
            end
        end
    endtask

    task automatic test_reset();
        checks++;
        if ({o_rx_ready, o_tx_valid, o_wr_valid, o_rd_ready, o_go, o_busy} !== 6'b0 ||
            o_tx_data !== 8'h00 || o_addr !== 32'h0 || o_data !== '0 || o_entry !== 32'h0 || o_wr_width !== 3'd1) begin
            fails++; $display("FAIL reset_values got ctl=%b addr=%h data=%h entry=%h width=%0d required all 0, width=1",
                {o_rx_ready, o_tx_valid, o_wr_valid, o_rd_ready, o_go, o_busy}, o_addr, o_data, o_entry, o_wr_width);
        end
    endtask

    task automatic test_write(input int delay);
        clear_logs();
        wr_delay = delay;
        send_hdr(8'h57, 32'h0000_1000, 16'd3);
        send_byte(8'h11);
        checks++;
        if (o_wr_valid !== 1'b1 || o_rx_ready !== 1'b0 || o_wr_width !== 3'd1) begin
            fails++; $display("FAIL write_latency got wr_valid=%b rx_ready=%b width=%0d required 1 0 1", o_wr_valid, o_rx_ready, o_wr_width);
        end
        send_byte(8'h22);
        send_byte(8'h33);
        wait_idle();
        wr_delay = 0;
        check_wr("write", '{32'h1000, 32'h1001, 32'h1002}, '{8'h11, 8'h22, 8'h33});
        check_tx("write", '{8'h06, 8'h66});
        checks++;
        if (stab_err != 0) begin fails++; $display("FAIL write_stable got %0d changes during wait, required 0", stab_err); end
    endtask

    task automatic test_read(input int stall_at);
        clear_logs();
        stall_after = stall_at;
        send_hdr(8'h52, 32'h0000_1000, 16'd3);
        wait_idle();
        stall_after = 0; tx_stall = 0;
        check_tx("read", '{8'h11, 8'h22, 8'h33, 8'h06});
        checks++;
        if (wa_q.size() != 0) begin fails++; $display("FAIL read_no_write got %0d writes required 0", wa_q.size()); end
    endtask

    task automatic test_go(input logic [31:0] a);
        clear_logs();
        send_hdr(8'h47, a, 16'h1234);
        wait_idle();
        repeat (2) @(negedge clk);
        check_tx("go", '{8'h06});
        checks++;
        if (go_cnt != 1) begin fails++; $display("FAIL go_pulse got %0d cycles required 1", go_cnt); end
        checks++;
        if (o_entry !== a) begin fails++; $display("FAIL go_entry got %h required %h", o_entry, a); end
    endtask

    task automatic test_bad_cmd();
        clear_logs();
        send_byte(8'h41);
        send_hdr(8'h52, 32'h0000_1000, 16'd0);
        wait_idle();
        check_tx("bad_cmd", '{8'h15, 8'h06});
        checks++;
        if (wa_q.size() != 0 || rd_cnt != 0) begin
            fails++; $display("FAIL bad_cmd_bus got wr=%0d rd=%0d required 0 0", wa_q.size(), rd_cnt);
        end
    endtask

    task automatic test_wrap();
        clear_logs();
        send_hdr(8'h57, 32'hFFFF_FFFF, 16'd2);
        send_byte(8'hFF);
        send_byte(8'h02);
        wait_idle();
        check_wr("wrap", '{32'hFFFF_FFFF, 32'h0000_0000}, '{8'hFF, 8'h02});
        check_tx("wrap", '{8'h06, 8'h01});
    endtask

    task automatic test_reset_mid_frame();
        clear_logs();
        send_hdr(8'h57, 32'h0000_4000, 16'd4);
        send_byte(8'hA1);
        send_byte(8'hA2);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({o_rx_ready, o_tx_valid, o_wr_valid, o_rd_ready, o_go, o_busy} !== 6'b0 ||
            o_addr !== 32'h0 || o_data !== '0 || o_tx_data !== 8'h00 || o_wr_width !== 3'd1) begin
            fails++; $display("FAIL reset_mid_frame got ctl=%b addr=%h data=%h width=%0d required 0 0 0 1",
                {o_rx_ready, o_tx_valid, o_wr_valid, o_rd_ready, o_go, o_busy}, o_addr, o_data, o_wr_width);
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (tx_q.size() != 0) begin fails++; $display("FAIL reset_no_ack got %0d tx bytes required 0", tx_q.size()); end
        test_go(32'h0000_0300);
    endtask

    initial begin
        #3;
        test_reset();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        test_write(0);
        test_write(5);
        test_read(0);
        test_read(1);
        test_go(32'h0000_0200);
        test_bad_cmd();
        test_wrap();
        test_reset_mid_frame();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule

// File: doc/uart_loader.md
# uart_loader

- Bus initiator that turns a byte-serial command stream from the UART receiver into memory-bus transactions.
- Sits between the `uartwriter` RX/TX byte ports and a CPU-side port of `memmap`, using the same valid/ready write and read handshake as `core`.
- Used to load program images into RAM, read memory back and hand control to a boot address, with no CPU software involved.
- Handles one command at a time, with byte-wide bus transactions only.

## Interface
Parameters:
- `DATA_WIDTH`, default `` `DATA_WIDTH ``: bus data width; must be ≥ 8.

Ports (one clock; reset is asynchronous and active-low):
- `i_clk` in 1: clock.
- `i_rst` in 1: asynchronous, active-low reset.
- `i_rx_data` in 8: received byte.
- `i_rx_valid` in 1: a received byte is available.
- `o_rx_ready` out 1: loader accepts a byte. Transfer happens when valid&ready.
- `o_tx_data` out 8: byte to transmit.
- `o_tx_valid` out 1: transmit request.
- `i_tx_ready` in 1: TX FIFO accepts the byte.
- `o_addr` out 32: bus address.
- `o_data` out DATA_WIDTH: write data. Byte in [7:0], upper bits 0.
- `o_wr_valid` out 1: write request.
- `i_wr_ready` in 1: write accepted.
- `o_wr_width` out 3: always 3'd1 (one byte).
- `i_data` in DATA_WIDTH: read data; only [7:0] is used.
- `i_rd_valid` in 1: read data valid.
- `o_rd_ready` out 1: read request.
- `o_go` out 1: one-cycle pulse that starts execution.
- `o_entry` out 32: boot address, held stable from the `o_go` pulse onward.
- `o_busy` out 1: high in every state except IDLE.

## Operation
Frame format: CMD byte, then ADDR (4 bytes, little-endian), then LEN (2 bytes, little-endian), then payload.

- **CMD 0x57 'W':**
  - Receives LEN payload bytes.
  - Writes each byte to ADDR+i, i = 0..LEN-1.
  - Then transmits ACK 0x06, then SUM = payload sum mod 256.
- **CMD 0x52 'R':**
  - Reads bytes from ADDR+i, i = 0..LEN-1.
  - Transmits each byte `i_data[7:0]` in order, then ACK 0x06.
- **CMD 0x47 'G':**
  - Transmits ACK 0x06.
  - Latches `o_entry`=ADDR, then pulses `o_go` for one cycle. LEN is ignored.
- **Any other CMD:** transmits NAK 0x15 and returns to IDLE. The loader does not consume a header, so the next byte is treated as a new CMD.

State machine:
- IDLE: byte received → HDR if command is valid, else NAK.
- HDR: after 6 bytes → W_RX, RD_BUS, or ACK, by command. LEN=0 goes directly to ACK.
- W_RX: byte received → W_BUS.
- W_BUS: write accepted → W_RX if bytes remain, else ACK.
- RD_BUS: read data valid → RD_TX.
- RD_TX: TX accepted → RD_BUS if bytes remain, else ACK.
- ACK: TX accepted → SUM for 'W'; GO for 'G'; IDLE for 'R'.
- SUM: TX accepted → IDLE.
- GO: one cycle → IDLE.
- NAK: TX accepted → IDLE.

Arithmetic and width rules:
- Address = ADDR + i, 32-bit, wraps modulo 2^32 (0xFFFFFFFF+1 = 0x00000000).
- Remaining count is 16 bits, so LEN=0xFFFF means 65535 bytes.
- SUM is 8 bits and wraps. It resets to 0 at each CMD byte.

## Timing
Reset values:
- All outputs are 0 except `o_wr_width`, which is 3'd1.
- State is IDLE and SUM is 0.
- Reset mid-frame abandons the frame immediately and asynchronously; outputs drop in the same instant. No ACK is sent.

Handshake rules:
- Once `o_wr_valid`, `o_rd_ready` or `o_tx_valid` is raised, it stays high with address/data stable until the matching ready/valid is seen. It drops on the cycle after acceptance.
- `o_rx_ready` is high only in IDLE, HDR and W_RX.
- `o_rd_ready` is high only in RD_BUS.
- `o_wr_valid` is high only in W_BUS.
- `o_tx_valid` is high only in RD_TX, ACK, SUM and NAK.
- All outputs are registered.

Latency:
- At most 1 idle cycle between completing one handshake and raising the next request.
- A 'W' byte received in cycle t has `o_wr_valid` high at t+1.
- A read with `i_rd_valid` in cycle t has `o_tx_valid` high at t+1.
- A read with `i_rd_valid` already high in the first RD_BUS cycle completes in 1 cycle.

Boundary conditions:
- RX bytes arriving while `o_rx_ready` is low are held by the receiver FIFO and are not lost here.
- Bus error signals are not observed: a `memmap` invalid-address flag does not abort the frame.

## Structure
- Package `loader_pkg` holds:
  - constants CMD_WRITE, CMD_READ, CMD_GO, ACK_BYTE, NAK_BYTE, WIDTH_BYTE = 3'd1;
  - enum `loader_state_t` with the states above.
- No sub-module is needed. The header is a 48-bit shift register (or byte-indexed register) with a 3-bit byte counter, all inline.

## Test plan
- 'W' to 0x00001000, LEN=3, payload 0x11 0x22 0x33:
  - three writes, addr 0x1000/0x1001/0x1002, width 1;
  - TX sends 0x06 then 0x66.
  - Repeat with `i_wr_ready` delayed 5 cycles: data/addr held stable for the whole wait.
- 'R' from 0x1000, LEN=3, after the write above:
  - TX sends 0x11 0x22 0x33 0x06.
  - Repeat with `i_tx_ready` low 10 cycles mid-stream: no byte dropped or duplicated.
- 'G' with ADDR 0x00000200:
  - TX sends 0x06;
  - `o_go` high for exactly one cycle;
  - `o_entry`=0x200.
- Byte 0x41 ('A') followed by a valid 'R' frame with LEN=0:
  - TX sends 0x15, then 0x06;
  - no bus activity.
- 'W' at ADDR 0xFFFFFFFF, LEN=2, payload 0xFF 0x02:
  - writes to 0xFFFFFFFF and then 0x00000000;
  - SUM = 0x01.
- Reset asserted in the middle of a 'W' payload:
  - all outputs return to reset values immediately;
  - a following 'G' frame is accepted normally.
